// File: rtl/toeplitz_stream_if.sv
// Seed, raw-word input and extracted-word output bundle for toeplitz_stream.
// The master side drives the seed, the raw words and q_ready; the slave side is the extractor.
interface toeplitz_stream_if #(
    parameter int N     = 256,
    parameter int L     = 128,
    parameter int WIDTH = 8
);
    logic [N+L-2:0] seed_in;
    logic           seed_load;
    logic           seed_pending;
    logic [WIDTH-1:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic [L-1:0]   q;
    logic           q_valid;
    logic           q_ready;

    modport master (
        output seed_in, seed_load, in_data, in_valid, q_ready,
        input  seed_pending, in_ready, q, q_valid
    );

    modport slave (
        input  seed_in, seed_load, in_data, in_valid, q_ready,
        output seed_pending, in_ready, q, q_valid
    );
endinterface

// File: rtl/toeplitz_stream.sv
// Streaming Toeplitz extractor: folds N raw bits, WIDTH per word, into one L-bit word using a double-buffered seed.
// q is valid one cycle after the last word of a block; a held q stalls only the next block's last word.
module toeplitz_stream #(
    parameter int N     = 256,
    parameter int L     = 128,
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    toeplitz_stream_if.slave bus
);
    localparam int WORDS = N / WIDTH;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int S     = N + L - 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    logic [CW-1:0] wcnt;
    logic [S-1:0]  pend_seed;
    logic [S-1:0]  act_seed;
    logic          seed_pend_r;
    logic          seeded;
    logic [L-1:0]  acc;
    logic [L-1:0]  q_r;
    logic          q_vld_r;

    logic          last_word;
    logic          xfer;
    logic          in_rdy;
    logic          accept;
    logic [S-1:0]  shifted;
    logic [L-1:0]  contrib;

    // Word k covers x[N-1-k*WIDTH -: WIDTH], so its columns start k*WIDTH bits into the seed.
    always_comb begin
        last_word = (wcnt == LAST);
        xfer      = (wcnt == '0) && seed_pend_r;
        in_rdy    = seeded && !xfer && !(last_word && q_vld_r && !bus.q_ready);
        accept    = bus.in_valid && in_rdy;
        shifted   = act_seed >> (int'(wcnt) * WIDTH);
        contrib   = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (bus.in_data[b]) begin
                contrib = contrib ^ shifted[WIDTH-1-b +: L];
            end
        end
    end

    assign bus.in_ready     = in_rdy;
    assign bus.q            = q_r;
    assign bus.q_valid      = q_vld_r;
    assign bus.seed_pending = seed_pend_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt        <= '0;
            pend_seed   <= '0;
            act_seed    <= '0;
            seed_pend_r <= 1'b0;
            seeded      <= 1'b0;
            acc         <= '0;
            q_r         <= '0;
            q_vld_r     <= 1'b0;
        end else begin
            if (bus.seed_load) begin
                pend_seed   <= bus.seed_in;
                seed_pend_r <= 1'b1;
            end
            // A load landing on the transfer edge stays pending for the following block.
            if (xfer) begin
                act_seed <= pend_seed;
                seeded   <= 1'b1;
                if (!bus.seed_load) begin
                    seed_pend_r <= 1'b0;
                end
            end
            if (q_vld_r && bus.q_ready) begin
                q_vld_r <= 1'b0;
            end
            if (accept) begin
                if (last_word) begin
                    wcnt    <= '0;
                    acc     <= '0;
                    q_r     <= acc ^ contrib;
                    q_vld_r <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                    acc  <= acc ^ contrib;
                end
            end
        end
    end
endmodule

// File: tb/tb_toeplitz_stream.sv
// Directed bench: a small N=16/L=8/WIDTH=4 instance for the flow-control cases and a full-size instance.
module tb_toeplitz_stream;
    logic clk;
    logic rst_s;
    logic rst_b;
    int   checks;
    int   failures;

    toeplitz_stream_if #(.N(16),  .L(8),   .WIDTH(4)) sif();
    toeplitz_stream_if #(.N(256), .L(128), .WIDTH(8)) bif();

    toeplitz_stream #(.N(16), .L(8), .WIDTH(4)) u_small (
        .clk   (clk),
        .reset (rst_s),
        .bus   (sif)
    );

    toeplitz_stream #(.N(256), .L(128), .WIDTH(8)) u_big (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- small instance helpers ----------------
    task automatic s_seed(input logic [22:0] s);
        sif.seed_in   = s;
        sif.seed_load = 1'b1;
        step();
        sif.seed_load = 1'b0;
    endtask

    task automatic s_word(input logic [3:0] w);
        int n;
        n = 0;
        sif.in_data  = w;
        sif.in_valid = 1'b1;
        while (!sif.in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("s_word_timeout", 128'(n), 128'd0);
        step();
        sif.in_valid = 1'b0;
    endtask

    task automatic s_block(input logic [15:0] x);
        for (int k = 0; k < 4; k++) s_word(x[15-4*k -: 4]);
    endtask

    task automatic s_consume();
        sif.q_ready = 1'b1;
        step();
        sif.q_ready = 1'b0;
    endtask

    // ---------------- full-size instance helpers ----------------
    task automatic b_seed(input logic [382:0] s);
        bif.seed_in   = s;
        bif.seed_load = 1'b1;
        step();
        bif.seed_load = 1'b0;
    endtask

    task automatic b_word(input logic [7:0] w);
        int n;
        n = 0;
        bif.in_data  = w;
        bif.in_valid = 1'b1;
        while (!bif.in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("b_word_timeout", 128'(n), 128'd0);
        step();
        bif.in_valid = 1'b0;
    endtask

    task automatic b_block(input logic [255:0] x);
        for (int k = 0; k < 32; k++) b_word(x[255-8*k -: 8]);
    endtask

    task automatic b_consume();
        bif.q_ready = 1'b1;
        step();
        bif.q_ready = 1'b0;
    endtask

    logic [255:0] vec [4];
    logic [382:0] seed_id;
    logic [382:0] seed_two;
    logic [127:0] lo;
    int           n_rdy;

    initial begin
        checks   = 0;
        failures = 0;
        rst_s = 1'b1;
        rst_b = 1'b1;
        sif.seed_in = '0; sif.seed_load = 1'b0; sif.in_data = '0; sif.in_valid = 1'b0; sif.q_ready = 1'b0;
        bif.seed_in = '0; bif.seed_load = 1'b0; bif.in_data = '0; bif.in_valid = 1'b0; bif.q_ready = 1'b0;
        vec[0] = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
        vec[1] = 256'hDEADBEEFCAFEBABE_0123456789ABCDEF_A5A5A5A55A5A5A5A_FFFF00000000FFFF;
        vec[2] = 256'h8000000000000000_0000000000000001_8000000000000000_0000000000000001;
        vec[3] = {256{1'b1}};
        seed_id  = 383'd1 << 255;
        seed_two = (383'd1 << 255) | (383'd1 << 256);

        repeat (3) step();
        check("rst_q",        128'(sif.q),            128'h0);
        check("rst_q_valid",  128'(sif.q_valid),      128'h0);
        check("rst_in_ready", 128'(sif.in_ready),     128'h0);
        check("rst_pending",  128'(sif.seed_pending), 128'h0);
        rst_s = 1'b0;
        rst_b = 1'b0;

        // Unseeded: input must never be taken.
        n_rdy = 0;
        sif.in_valid = 1'b1;
        sif.in_data  = 4'hF;
        for (int i = 0; i < 20; i++) begin
            if (sif.in_ready) n_rdy++;
            step();
        end
        sif.in_valid = 1'b0;
        check("unseeded_rdy_cycles", 128'(n_rdy),       128'd0);
        check("unseeded_q_valid",    128'(sif.q_valid), 128'h0);

        // Identity seed: y = x[7:0].
        s_seed(23'h008000);
        check("load_pending",  128'(sif.seed_pending), 128'h1);
        check("load_rdy_low",  128'(sif.in_ready),     128'h0);
        step();
        check("xfer_rdy",      128'(sif.in_ready),     128'h1);
        check("xfer_pend_clr", 128'(sif.seed_pending), 128'h0);
        s_block(16'hA5C3);
        check("id_q_valid", 128'(sif.q_valid), 128'h1);
        check("id_q",       128'(sif.q),       128'hC3);
        s_consume();
        check("id_consumed", 128'(sif.q_valid), 128'h0);

        // All-ones seed: y[i] = parity of x.
        s_seed(23'h7FFFFF);
        s_block(16'h0001);
        check("ones_q_0001", 128'(sif.q), 128'hFF);
        s_consume();
        s_block(16'h0003);
        check("ones_q_0003", 128'(sif.q), 128'h00);
        s_consume();

        // Backpressure: q held, only the last word of the next block stalls.
        s_seed(23'h008000);
        s_block(16'h00AA);
        check("bp_q_first", 128'(sif.q), 128'hAA);
        for (int k = 0; k < 3; k++) begin
            sif.in_data  = (k == 2) ? 4'h5 : 4'h0;
            sif.in_valid = 1'b1;
            check("bp_rdy_early", 128'(sif.in_ready), 128'h1);
            step();
        end
        sif.in_data = 4'h5;
        check("bp_rdy_last_low", 128'(sif.in_ready), 128'h0);
        repeat (2) step();
        check("bp_q_held",       128'(sif.q),        128'hAA);
        check("bp_q_valid_held", 128'(sif.q_valid),  128'h1);
        check("bp_rdy_still",    128'(sif.in_ready), 128'h0);
        sif.q_ready = 1'b1;
        #1;
        check("bp_rdy_release", 128'(sif.in_ready), 128'h1);
        step();
        sif.q_ready  = 1'b0;
        sif.in_valid = 1'b0;
        check("bp_q_second",     128'(sif.q),       128'h55);
        check("bp_q_valid_kept", 128'(sif.q_valid), 128'h1);
        s_consume();

        // Mid-block reseed only applies to the next block.
        s_word(4'h1);
        s_word(4'h2);
        s_seed(23'h010000);
        check("mid_pending", 128'(sif.seed_pending), 128'h1);
        s_word(4'h3);
        s_word(4'h4);
        check("mid_q_old_seed",  128'(sif.q),            128'h34);
        check("mid_pending_end", 128'(sif.seed_pending), 128'h1);
        check("mid_bubble",      128'(sif.in_ready),     128'h0);
        s_consume();
        check("mid_pend_clr",    128'(sif.seed_pending), 128'h0);
        check("mid_rdy_after",   128'(sif.in_ready),     128'h1);
        s_block(16'h1234);
        check("mid_q_new_seed",  128'(sif.q),            128'h68);
        s_consume();

        // Full size: identity then two-tap seed (y = lo ^ (lo << 1)).
        b_seed(seed_id);
        for (int v = 0; v < 2; v++) begin
            b_block(vec[v]);
            lo = vec[v][127:0];
            check("big_id_q", bif.q, lo);
            b_consume();
        end
        b_seed(seed_two);
        for (int v = 2; v < 4; v++) begin
            b_block(vec[v]);
            lo = vec[v][127:0];
            check("big_two_q", bif.q, lo ^ (lo << 1));
            b_consume();
        end

        // Reset after ten words of a fifth block.
        for (int k = 0; k < 10; k++) b_word(vec[0][255-8*k -: 8]);
        bif.in_valid = 1'b1;
        rst_b = 1'b1;
        step();
        check("big_rst_q",       bif.q,                   128'h0);
        check("big_rst_q_valid", 128'(bif.q_valid),      128'h0);
        check("big_rst_rdy",     128'(bif.in_ready),     128'h0);
        check("big_rst_pending", 128'(bif.seed_pending), 128'h0);
        rst_b = 1'b0;
        n_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            if (bif.in_ready) n_rdy++;
            step();
        end
        bif.in_valid = 1'b0;
        check("big_rst_unseeded_rdy", 128'(n_rdy), 128'd0);
        b_seed(seed_id);
        b_block(vec[1]);
        lo = vec[1][127:0];
        check("big_after_rst_q", bif.q, lo);
        b_consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/toeplitz_stream.md
# toeplitz_stream

Streaming Toeplitz-hash randomness extractor with runtime-loadable seed and valid/ready flow control on both sides. Consumes N-bit raw blocks as WIDTH-bit words and emits one L-bit extracted word per block. Generalises the fixed-seed parallel extractor: the seed is a port, the input can be stalled, and the output holds under backpressure. Sits between the raw entropy sampler and the output serializer.

## Interface
- N, 256, raw bits per block; N % WIDTH == 0, N >= WIDTH
- L, 128, extracted bits per block; 1 <= L <= N
- WIDTH, 8, raw bits per input word
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state including the seed
- seed_in  in  N+L-1  Toeplitz seed s[N+L-2:0]
- seed_load  in  1  single-cycle request to capture seed_in
- seed_pending  out  1  captured seed not yet active
- in_data  in  WIDTH  raw word
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid && in_ready
- q  out  L  extracted word
- q_valid  out  1  q holds an unconsumed result
- q_ready  in  1  consumer takes q when q_valid && q_ready

## Operation
- Math: y[i] = XOR over j of (x[j] & s[i-j+N-1]), i in 0..L-1, j in 0..N-1. The column for x[j] is s[N-1-j +: L].
- Word order: first accepted word of a block is x[N-1:N-WIDTH]. Word k carries x[N-WIDTH-k*WIDTH +: WIDTH]; in_data[WIDTH-1] is the higher x index.
- Word counter wcnt runs 0..N/WIDTH-1. It wraps to 0 on acceptance of the last word.
- Accumulator acc[L-1:0]: on each accepted word, acc ^= XOR of the WIDTH selected columns.
- On the last word, q <= acc ^ contribution, q_valid <= 1, acc <= 0.
- Seed path, two registers: pending (written by seed_load) and active (used for the arithmetic).
- seed_load at any time: pending <= seed_in, seed_pending <= 1. A second load before transfer overwrites the first.
- Transfer pending -> active only when wcnt == 0 and seed_pending. During that cycle in_ready = 0. seed_pending clears on that edge; sets seeded flag.
- A seed load mid-block never affects the block in progress. It takes effect at the next block boundary.
- in_ready = seeded && !(wcnt==0 && seed_pending) && !(wcnt==N/WIDTH-1 && q_valid && !q_ready). The q_ready term is combinational.
- q_valid clears on q_valid && q_ready unless a new result loads in the same edge; in that case the new q loads and q_valid stays 1.

## Timing
- Reset values: q=0, q_valid=0, in_ready=0, seed_pending=0, seeded=0, wcnt=0, acc=0, active=0, pending=0.
- Unseeded after reset: in_ready stays 0 until the first transfer.
- seed_load in cycle t: seed_pending=1 at t+1; transfer edge at end of t+1 if wcnt==0; in_ready may be 1 from t+2.
- Throughput: one word per cycle; one block per N/WIDTH cycles when seeded and unstalled, except a one-cycle bubble per seed transfer.
- Latency: last word accepted in cycle t -> q/q_valid valid from t+1.
- Backpressure: only the last word of a block stalls. Words 0..N/WIDTH-2 proceed while q is held.
- q is stable while q_valid && !q_ready.
- Reset mid-block: the partial block, the held q and both seeds are discarded. A fresh seed_load is required.

## Test plan
Test parameters are N=16, L=8, WIDTH=4 unless stated.
- No seed loaded, in_valid=1 for 20 cycles -> in_ready=0 throughout, q_valid=0.
- Load s with only bit s[15]=1 (identity). Feed x=16'hA5C3 as words A,5,C,3 back-to-back -> q=8'hC3, q_valid one cycle after word 3.
- Load all-ones seed. Feed x=16'h0001 -> q=8'hFF. Then feed x=16'h0003 -> q=8'h00.
- Identity seed, q_ready=0, feed two blocks 16'h00AA then 16'h0055:
  - q=8'hAA holds.
  - in_ready drops only at the second block's word 3.
  - Raising q_ready accepts 8'h55 next.
- Identity seed active. Mid-block (after 2 words of 16'h1234), seed_load with only s[16]=1:
  - Current block still gives q=8'h34; seed_pending=1.
  - One bubble follows; next block 16'h1234 gives q=8'h68 (y[i]=x[i-1]).
- Full params N=256, L=128, WIDTH=8, seeded from the team's golden seed file. Stream the four golden x vectors, then assert reset after 10 words of a fifth block:
  - Outputs match the golden y files.
  - After reset: q=0, q_valid=0, in_ready=0 until reseeded.
